// File: rtl/char_pkg.sv
// Character controller types, default physics constants and the damage helper.
package char_pkg;
    import vga_pkg::*;

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_RISING   = 2'd1,
        ST_FALLING  = 2'd2,
        ST_DEAD     = 2'd3
    } mstate_t;

    localparam int DEF_POS_W         = 12;
    localparam int DEF_SCREEN_W      = HOR_PIXELS;
    localparam int DEF_CHAR_W        = 19;
    localparam int DEF_CHAR_H        = 27;
    localparam int DEF_GROUND_Y      = VER_PIXELS - 52 - 27;
    localparam int DEF_SPAWN_X       = HOR_PIXELS / 5;
    localparam int DEF_TICK_DIV      = 1_083_333;
    localparam int DEF_MOVE_STEP     = 5;
    localparam int DEF_JUMP_V0       = 14;
    localparam int DEF_GRAVITY       = 1;
    localparam int DEF_MAX_FALL      = 12;
    localparam int DEF_HP_MAX        = 10;
    localparam int DEF_INVULN_FRAMES = 30;
    localparam int DEF_ATK_FRAMES    = 8;
    localparam int DEF_ATK_COOLDOWN  = 20;

    // Frame-count timers (invuln, attack, cooldown) share this width.
    localparam int TMR_W = 8;

    function automatic logic [3:0] hp_after_hit(input logic [3:0] hp, input logic [3:0] dmg);
        return (dmg >= hp) ? 4'd0 : hp - dmg;
    endfunction
endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared by the draw pipeline and gameplay blocks.
package vga_pkg;
    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
endpackage

// File: rtl/char_motion_frame_tick_gen.sv
// Free-running divider producing a registered one-cycle strobe every TICK_DIV clocks.
module frame_tick_gen #(
    parameter int TICK_DIV = 1_083_333
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Strobe is registered one count early so it is high exactly while cnt == TICK_DIV-1.
    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_q == CNT_W'(TICK_DIV - 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;
endmodule

// File: rtl/char_motion.sv
// Player motion/health controller: jump physics FSM, damage with i-frames,
// death/respawn and an edge-triggered attack with cooldown.
module char_motion
    import char_pkg::*;
#(
    parameter int POS_W         = DEF_POS_W,
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int CHAR_W        = DEF_CHAR_W,
    parameter int CHAR_H        = DEF_CHAR_H,
    parameter int GROUND_Y      = DEF_GROUND_Y,
    parameter int SPAWN_X       = DEF_SPAWN_X,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int MOVE_STEP     = DEF_MOVE_STEP,
    parameter int JUMP_V0       = DEF_JUMP_V0,
    parameter int GRAVITY       = DEF_GRAVITY,
    parameter int MAX_FALL      = DEF_MAX_FALL,
    parameter int HP_MAX        = DEF_HP_MAX,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int ATK_FRAMES    = DEF_ATK_FRAMES,
    parameter int ATK_COOLDOWN  = DEF_ATK_COOLDOWN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stepleft,
    input  logic             stepright,
    input  logic             stepjump,
    input  logic             on_ground,
    input  logic             mouse_left,
    input  logic             hit,
    input  logic [3:0]       hit_dmg,
    input  logic             respawn,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [POS_W-1:0] ground_lvl,
    output logic [3:0]       char_hp,
    output logic             flip_h,
    output logic             draw_weapon,
    output logic             invuln,
    output logic             alive,
    output logic             frame_tick,
    output logic [1:0]       mstate
);
    // state     | meaning
    // GROUNDED  | standing on a surface, may jump or walk off
    // RISING    | upward velocity, decays by GRAVITY each frame
    // FALLING   | downward velocity, capped at MAX_FALL, lands on on_ground/floor
    // DEAD      | HP exhausted, frozen until respawn

    localparam logic [POS_W-1:0]          X_SPAWN  = POS_W'(SPAWN_X);
    localparam logic [POS_W-1:0]          Y_GND    = POS_W'(GROUND_Y);
    localparam logic [POS_W-1:0]          X_MIN    = POS_W'(CHAR_W + MOVE_STEP);
    localparam logic [POS_W-1:0]          X_MAX    = POS_W'(SCREEN_W - CHAR_W - MOVE_STEP);
    localparam logic [POS_W-1:0]          X_STEP   = POS_W'(MOVE_STEP);
    localparam logic signed [POS_W+1:0]   Y_GND_S  = (POS_W+2)'(GROUND_Y);
    localparam logic signed [7:0]         V_JUMP   = 8'(JUMP_V0);
    localparam logic signed [7:0]         V_GRAV   = 8'(GRAVITY);
    localparam logic signed [7:0]         V_MIN    = -8'(MAX_FALL);
    localparam logic [3:0]                HP_FULL  = 4'(HP_MAX);

    logic [POS_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [7:0] vel_y_q, vel_y_d;
    mstate_t           state_q, state_d;
    logic [3:0]        hp_q, hp_d;
    logic              flip_q, flip_d, draw_q, draw_d, mouse_prev_q, mouse_prev_d;
    logic [TMR_W-1:0]  inv_cnt_q, inv_cnt_d, atk_cnt_q, atk_cnt_d, cd_cnt_q, cd_cnt_d;

    logic                    tick;
    logic signed [POS_W+1:0] y_next;
    logic signed [7:0]       vel_dec;
    logic                    hit_ok;

    frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (tick)
    );

    always_comb begin
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        vel_y_d      = vel_y_q;
        state_d      = state_q;
        hp_d         = hp_q;
        flip_d       = flip_q;
        draw_d       = draw_q;
        inv_cnt_d    = inv_cnt_q;
        atk_cnt_d    = atk_cnt_q;
        cd_cnt_d     = cd_cnt_q;
        mouse_prev_d = mouse_left;
        y_next       = $signed({2'b00, pos_y_q}) - (POS_W+2)'(vel_y_q);
        vel_dec      = vel_y_q - V_GRAV;
        hit_ok       = hit && (state_q != ST_DEAD) && (inv_cnt_q == '0);

        if (state_q != ST_DEAD) begin
            if (stepleft)
                flip_d = 1'b1;
            else if (stepright)
                flip_d = 1'b0;

            if (tick) begin
                if (stepleft) begin
                    if (pos_x_q > X_MIN) pos_x_d = pos_x_q - X_STEP;
                end else if (stepright) begin
                    if (pos_x_q < X_MAX) pos_x_d = pos_x_q + X_STEP;
                end

                case (state_q)
                    ST_GROUNDED: begin
                        if (stepjump && on_ground) begin
                            state_d = ST_RISING;
                            vel_y_d = V_JUMP;
                        end else if (!on_ground) begin
                            state_d = ST_FALLING;
                            vel_y_d = '0;
                        end
                    end
                    ST_RISING: begin
                        if (y_next[POS_W+1]) begin
                            pos_y_d = '0;
                            vel_y_d = '0;
                            state_d = ST_FALLING;
                        end else begin
                            pos_y_d = y_next[POS_W-1:0];
                            vel_y_d = vel_dec;
                            if (vel_dec <= 8'sd0) state_d = ST_FALLING;
                        end
                    end
                    ST_FALLING: begin
                        if (on_ground) begin
                            state_d = ST_GROUNDED;
                            vel_y_d = '0;
                        end else if (y_next >= Y_GND_S) begin
                            pos_y_d = Y_GND;
                            vel_y_d = '0;
                            state_d = ST_GROUNDED;
                        end else if (y_next[POS_W+1]) begin
                            pos_y_d = '0;
                            vel_y_d = '0;
                        end else begin
                            pos_y_d = y_next[POS_W-1:0];
                            vel_y_d = (vel_dec < V_MIN) ? V_MIN : vel_dec;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (tick) begin
            if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - TMR_W'(1);
            if (atk_cnt_q != '0) begin
                atk_cnt_d = atk_cnt_q - TMR_W'(1);
                if (atk_cnt_q == TMR_W'(1)) begin
                    draw_d   = 1'b0;
                    cd_cnt_d = TMR_W'(ATK_COOLDOWN);
                end
            end else if (cd_cnt_q != '0) begin
                cd_cnt_d = cd_cnt_q - TMR_W'(1);
            end
        end

        if (mouse_left && !mouse_prev_q && atk_cnt_q == '0 && cd_cnt_q == '0
            && state_q != ST_DEAD) begin
            draw_d    = 1'b1;
            atk_cnt_d = TMR_W'(ATK_FRAMES);
        end

        // A hit overrides the frame decrement so the i-frame window is always full length.
        if (hit_ok) begin
            hp_d      = hp_after_hit(hp_q, hit_dmg);
            inv_cnt_d = TMR_W'(INVULN_FRAMES);
            if (hp_d == 4'd0) begin
                state_d   = ST_DEAD;
                draw_d    = 1'b0;
                atk_cnt_d = '0;
                cd_cnt_d  = '0;
            end
        end

        if (state_q == ST_DEAD && respawn) begin
            pos_x_d   = X_SPAWN;
            pos_y_d   = Y_GND;
            vel_y_d   = '0;
            state_d   = ST_GROUNDED;
            hp_d      = HP_FULL;
            flip_d    = 1'b0;
            draw_d    = 1'b0;
            inv_cnt_d = '0;
            atk_cnt_d = '0;
            cd_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x_q      <= X_SPAWN;
            pos_y_q      <= Y_GND;
            vel_y_q      <= '0;
            state_q      <= ST_GROUNDED;
            hp_q         <= HP_FULL;
            flip_q       <= 1'b0;
            draw_q       <= 1'b0;
            inv_cnt_q    <= '0;
            atk_cnt_q    <= '0;
            cd_cnt_q     <= '0;
            mouse_prev_q <= 1'b0;
        end else begin
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            vel_y_q      <= vel_y_d;
            state_q      <= state_d;
            hp_q         <= hp_d;
            flip_q       <= flip_d;
            draw_q       <= draw_d;
            inv_cnt_q    <= inv_cnt_d;
            atk_cnt_q    <= atk_cnt_d;
            cd_cnt_q     <= cd_cnt_d;
            mouse_prev_q <= mouse_prev_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign ground_lvl  = Y_GND;
    assign char_hp     = hp_q;
    assign flip_h      = flip_q;
    assign draw_weapon = draw_q;
    assign invuln      = (inv_cnt_q != '0);
    assign alive       = (state_q != ST_DEAD);
    assign frame_tick  = tick;
    assign mstate      = state_q;
endmodule

// File: tb/tb_char_motion.sv
// Directed scoreboard bench for char_motion at 1024x768 with a 4-cycle frame tick.
module tb_char_motion;
    logic        clk = 1'b0;
    logic        rst, stepleft, stepright, stepjump, on_ground, mouse_left, hit, respawn;
    logic [3:0]  hit_dmg;
    logic [11:0] pos_x, pos_y, ground_lvl;
    logic [3:0]  char_hp;
    logic        flip_h, draw_weapon, invuln, alive, frame_tick;
    logic [1:0]  mstate;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    char_motion #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .stepleft    (stepleft),
        .stepright   (stepright),
        .stepjump    (stepjump),
        .on_ground   (on_ground),
        .mouse_left  (mouse_left),
        .hit         (hit),
        .hit_dmg     (hit_dmg),
        .respawn     (respawn),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .ground_lvl  (ground_lvl),
        .char_hp     (char_hp),
        .flip_h      (flip_h),
        .draw_weapon (draw_weapon),
        .invuln      (invuln),
        .alive       (alive),
        .frame_tick  (frame_tick),
        .mstate      (mstate)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: got %0d with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    // Returns at the negedge of the cycle after a frame tick, so its effects are visible.
    task automatic next_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (frame_tick === 1'b1) else begin
            errors++;
            $error("FAIL tick_timeout: frame_tick=%b required 1", frame_tick);
        end
        @(negedge clk);
    endtask

    initial begin
        int py, v, x, xd, high_ticks, rises;
        logic prev_draw;
        bit landed;

        rst = 1'b1; stepleft = 1'b0; stepright = 1'b0; stepjump = 1'b0; on_ground = 1'b1;
        mouse_left = 1'b0; hit = 1'b0; hit_dmg = 4'd0; respawn = 1'b0;

        // Reset state and first tick timing
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push("rst_px", 204); push("rst_py", 689); push("rst_hp", 10); push("rst_st", 0);
        push("rst_alive", 1); push("rst_flip", 0); push("rst_draw", 0); push("rst_inv", 0);
        push("rst_gnd", 689); push("tick_c0", 0);
        pop_chk(pos_x); pop_chk(pos_y); pop_chk(char_hp); pop_chk(mstate);
        pop_chk(alive); pop_chk(flip_h); pop_chk(draw_weapon); pop_chk(invuln);
        pop_chk(ground_lvl); pop_chk(frame_tick);
        push("tick_c1", 0); push("tick_c2", 0); push("tick_c3", 1);
        @(negedge clk); pop_chk(frame_tick);
        @(negedge clk); pop_chk(frame_tick);
        @(negedge clk); pop_chk(frame_tick);
        @(negedge clk);

        // Jump arc
        stepjump = 1'b1;
        push("jump_st", 1); push("jump_py", 689);
        next_frame();
        pop_chk(mstate); pop_chk(pos_y);
        stepjump = 1'b0; on_ground = 1'b0;
        py = 689; v = 14;
        for (int i = 0; i < 14; i++) begin
            py = py - v; v = v - 1;
            push("rise_py", py);
            next_frame();
            pop_chk(pos_y);
        end
        push("apex_st", 2); push("apex_py", 584);
        pop_chk(mstate); pop_chk(pos_y);
        v = 0; landed = 0;
        for (int i = 0; i < 40 && !landed; i++) begin
            if (py - v >= 689) begin
                py = 689; landed = 1;
            end else begin
                py = py - v;
                v = (v - 1 < -12) ? -12 : v - 1;
            end
            push("fall_py", py);
            next_frame();
            pop_chk(pos_y);
        end
        push("land_st", 0);
        pop_chk(mstate);
        on_ground = 1'b1;

        // Horizontal clamp
        stepright = 1'b1;
        x = 204;
        for (int i = 0; i < 300; i++) begin
            if (x < 1024 - 19 - 5) x = x + 5;
            next_frame();
        end
        push("right_px", x); push("right_flip", 0);
        pop_chk(pos_x); pop_chk(flip_h);
        stepleft = 1'b1;
        if (x > 19 + 5) x = x - 5;
        push("both_px", x); push("both_flip", 1);
        next_frame();
        pop_chk(pos_x); pop_chk(flip_h);
        stepleft = 1'b0; stepright = 1'b0;

        // Damage, invulnerability and death
        hit = 1'b1; hit_dmg = 4'd3;
        push("hit1_hp", 7); push("hit1_inv", 1); push("hit1_alive", 1);
        @(negedge clk);
        hit = 1'b0;
        pop_chk(char_hp); pop_chk(invuln); pop_chk(alive);
        for (int i = 0; i < 10; i++) next_frame();
        hit = 1'b1; hit_dmg = 4'd5;
        push("hit2_hp", 7); push("hit2_inv", 1);
        @(negedge clk);
        hit = 1'b0;
        pop_chk(char_hp); pop_chk(invuln);
        for (int i = 0; i < 19; i++) next_frame();
        push("inv29", 1);
        pop_chk(invuln);
        next_frame();
        push("inv30", 0);
        pop_chk(invuln);
        hit = 1'b1; hit_dmg = 4'd9;
        push("death_hp", 0); push("death_st", 3); push("death_alive", 0); push("death_draw", 0);
        @(negedge clk);
        hit = 1'b0;
        pop_chk(char_hp); pop_chk(mstate); pop_chk(alive); pop_chk(draw_weapon);
        stepright = 1'b1; stepjump = 1'b1;
        push("dead_px", x); push("dead_py", 689); push("dead_flip", 1);
        next_frame();
        pop_chk(pos_x); pop_chk(pos_y); pop_chk(flip_h);
        stepright = 1'b0; stepjump = 1'b0;
        respawn = 1'b1; hit = 1'b1; hit_dmg = 4'd4;
        push("resp_hp", 10); push("resp_px", 204); push("resp_py", 689); push("resp_st", 0);
        push("resp_alive", 1); push("resp_inv", 0); push("resp_flip", 0);
        @(negedge clk);
        respawn = 1'b0; hit = 1'b0;
        pop_chk(char_hp); pop_chk(pos_x); pop_chk(pos_y); pop_chk(mstate);
        pop_chk(alive); pop_chk(invuln); pop_chk(flip_h);

        // Attack: held button fires once for exactly ATK_FRAMES
        mouse_left = 1'b1;
        high_ticks = 0; rises = 0; prev_draw = 1'b0;
        push("hold_ticks", 8); push("hold_rises", 1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_tick && draw_weapon) high_ticks++;
            if (draw_weapon && !prev_draw) rises++;
            prev_draw = draw_weapon;
        end
        pop_chk(high_ticks); pop_chk(rises);
        mouse_left = 1'b0;
        next_frame();

        // Attack cooldown window
        mouse_left = 1'b1;
        push("atk_start", 1);
        @(negedge clk);
        mouse_left = 1'b0;
        pop_chk(draw_weapon);
        for (int i = 0; i < 7; i++) next_frame();
        push("atk_f7", 1);
        pop_chk(draw_weapon);
        next_frame();
        push("atk_f8", 0);
        pop_chk(draw_weapon);
        for (int i = 0; i < 7; i++) next_frame();
        mouse_left = 1'b1;
        push("cd_f15", 0);
        @(negedge clk);
        mouse_left = 1'b0;
        pop_chk(draw_weapon);
        for (int i = 0; i < 15; i++) next_frame();
        mouse_left = 1'b1;
        push("rearm_f30", 1);
        @(negedge clk);
        mouse_left = 1'b0;
        pop_chk(draw_weapon);

        // Reset mid-jump with attack active
        stepleft = 1'b1; stepjump = 1'b1;
        next_frame();
        stepleft = 1'b0; stepjump = 1'b0;
        hit = 1'b1; hit_dmg = 4'd2;
        push("pre_st", 1); push("pre_draw", 1); push("pre_inv", 1); push("pre_flip", 1);
        push("pre_hp", 8);
        @(negedge clk);
        hit = 1'b0;
        pop_chk(mstate); pop_chk(draw_weapon); pop_chk(invuln); pop_chk(flip_h); pop_chk(char_hp);
        rst = 1'b1;
        push("mid_px", 204); push("mid_py", 689); push("mid_hp", 10); push("mid_st", 0);
        push("mid_flip", 0); push("mid_draw", 0); push("mid_inv", 0); push("mid_alive", 1);
        push("mid_tick", 0);
        @(negedge clk);
        rst = 1'b0;
        pop_chk(pos_x); pop_chk(pos_y); pop_chk(char_hp); pop_chk(mstate);
        pop_chk(flip_h); pop_chk(draw_weapon); pop_chk(invuln); pop_chk(alive); pop_chk(frame_tick);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
